// File: rtl/root_child_scheduler_pkg.sv
// root_sched_pkg
// Shared types and constants for the root-level child scheduler and any
// other root-level arbiter that reuses rr_pick.
//   sched_state_t     : scheduler FSM states
//   NUM_CHILD_DEFAULT : default number of requesters/children
//   TIMEOUT_DEFAULT   : default watchdog length in WAIT cycles
//   CNT_W             : width of the saturating timeout counter
package root_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } sched_state_t;

  localparam int NUM_CHILD_DEFAULT = 5;
  localparam int TIMEOUT_DEFAULT   = 16;
  localparam int CNT_W             = 8;

endpackage

// File: rtl/root_child_scheduler_if.sv
// root_child_scheduler_if
// Bundles the request/grant handshake between the request sources, the
// scheduler and the inst_0..inst_N-1 children.
//   req_i         : level request per child (bit k = inst_k)
//   done_i        : completion pulse from the granted child
//   grant_o       : one-hot grant or all-zero
//   grant_idx_o   : binary index of current/last grant
//   start_o       : one-cycle start pulse to the granted child
//   busy_o        : scheduler is in a transaction
//   timeout_o     : one-cycle watchdog expiry pulse
//   timeout_cnt_o : saturating count of watchdog expiries
// Modports: master = scheduler side, slave = requester/child side.
interface root_child_scheduler_if import root_sched_pkg::*; #(
  parameter int NUM_CHILD = NUM_CHILD_DEFAULT,
  parameter int IDXW      = $clog2(NUM_CHILD)
) ();

  logic [NUM_CHILD-1:0] req_i;
  logic                 done_i;
  logic [NUM_CHILD-1:0] grant_o;
  logic [IDXW-1:0]      grant_idx_o;
  logic                 start_o;
  logic                 busy_o;
  logic                 timeout_o;
  logic [CNT_W-1:0]     timeout_cnt_o;

  modport master (
    input  req_i, done_i,
    output grant_o, grant_idx_o, start_o, busy_o, timeout_o, timeout_cnt_o
  );

  modport slave (
    output req_i, done_i,
    input  grant_o, grant_idx_o, start_o, busy_o, timeout_o, timeout_cnt_o
  );

endinterface

// File: rtl/root_child_scheduler_rr_pick.sv
// rr_pick
// Combinational round-robin picker: returns the first set bit of req at or
// after ptr, searching upward and wrapping past N-1 back to 0.
//   req   : request vector
//   ptr   : search start position (0..N-1)
//   valid : at least one request is set
//   idx   : index of the chosen request (0 when valid is low)
module rr_pick import root_sched_pkg::*; #(
  parameter int N    = NUM_CHILD_DEFAULT,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  localparam logic [IDXW:0] NW = (IDXW+1)'(N);

  // Rotating the doubled vector right by ptr puts the request at position
  // ptr in bit 0, so "first at or after ptr" becomes "lowest set bit".
  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;

  assign req2 = {req, req};
  assign rot  = N'(req2 >> ptr);

  // Each slot maps its rotated position back to a real index; a slot wins
  // only when no lower rotated slot is set, so at most one slot ORs in.
  for (genvar j = 0; j < N; j++) begin : g_slot
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] pos;
    logic            seen;
    logic [IDXW-1:0] acc;

    assign sum = {1'b0, ptr} + (IDXW+1)'(j);
    assign pos = (sum >= NW) ? IDXW'(sum - NW) : sum[IDXW-1:0];

    if (j == 0) begin : g_first
      assign seen = 1'b0;
      assign acc  = rot[0] ? pos : '0;
    end else begin : g_rest
      assign seen = g_slot[j-1].seen | rot[j-1];
      assign acc  = g_slot[j-1].acc | ((rot[j] && !seen) ? pos : '0);
    end
  end

  assign valid = |req;
  assign idx   = g_slot[N-1].acc;

endmodule

// File: rtl/root_child_scheduler.sv
// root_child_scheduler
// Round-robin scheduler sharing the root's child instances as a single
// execution resource: grants one child at a time, pulses start, holds the
// grant until done or watchdog expiry, then releases and advances priority.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : root_child_scheduler_if.master (requests, done, grant, status)
module root_child_scheduler import root_sched_pkg::*; #(
  parameter int NUM_CHILD = NUM_CHILD_DEFAULT,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int IDXW      = $clog2(NUM_CHILD)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  root_child_scheduler_if.master bus
);

  localparam int              WDW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_CHILD - 1);

  sched_state_t         state, state_n;
  logic [IDXW-1:0]      ptr, ptr_n;
  logic [WDW-1:0]       wdog, wdog_n;
  logic [NUM_CHILD-1:0] grant, grant_n;
  logic [IDXW-1:0]      grant_idx, grant_idx_n;
  logic                 start, start_n;
  logic                 busy, busy_n;
  logic                 tmo, tmo_n;
  logic [CNT_W-1:0]     tmo_cnt, tmo_cnt_n;

  logic                 pick_valid;
  logic [IDXW-1:0]      pick_idx;

  rr_pick #(
    .N    (NUM_CHILD),
    .IDXW (IDXW)
  ) u_pick (
    .req   (bus.req_i),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // All state and every output is registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      wdog      <= '0;
      grant     <= '0;
      grant_idx <= '0;
      start     <= 1'b0;
      busy      <= 1'b0;
      tmo       <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      wdog      <= wdog_n;
      grant     <= grant_n;
      grant_idx <= grant_idx_n;
      start     <= start_n;
      busy      <= busy_n;
      tmo       <= tmo_n;
      tmo_cnt   <= tmo_cnt_n;
    end
  end

  // Next-state and next-output logic. Pulses default low; everything else
  // holds unless the current state changes it. Done is checked before the
  // watchdog so a coincident done suppresses the timeout.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    wdog_n      = wdog;
    grant_n     = grant;
    grant_idx_n = grant_idx;
    start_n     = 1'b0;
    tmo_n       = 1'b0;
    tmo_cnt_n   = tmo_cnt;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n     = START;
          grant_n     = NUM_CHILD'(1) << pick_idx;
          grant_idx_n = pick_idx;
          start_n     = 1'b1;
          wdog_n      = '0;
        end
      end
      START: begin
        state_n = WAIT;
        wdog_n  = '0;
      end
      WAIT: begin
        if (bus.done_i) begin
          state_n = RELEASE;
          grant_n = '0;
        end else if (wdog == WD_LAST) begin
          state_n = RELEASE;
          grant_n = '0;
          tmo_n   = 1'b1;
          if (tmo_cnt != '1) tmo_cnt_n = tmo_cnt + CNT_W'(1);
        end else begin
          wdog_n = wdog + WDW'(1);
        end
      end
      RELEASE: begin
        state_n = IDLE;
        ptr_n   = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDXW'(1);
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.grant_o       = grant;
  assign bus.grant_idx_o   = grant_idx;
  assign bus.start_o       = start;
  assign bus.busy_o        = busy;
  assign bus.timeout_o     = tmo;
  assign bus.timeout_cnt_o = tmo_cnt;

endmodule

// File: tb/tb_root_child_scheduler.sv
// tb_root_child_scheduler
// Scoreboard bench for root_child_scheduler. The driver computes each
// expected grant from a round-robin reference model and queues it; a
// monitor pops the queue on every start pulse and follows the grant
// through WAIT and RELEASE.
module tb_root_child_scheduler;
  import root_sched_pkg::*;

  localparam int NC = 5;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  root_child_scheduler_if #(.NUM_CHILD(NC), .IDXW(3)) bus ();

  root_child_scheduler #(
    .NUM_CHILD (NC),
    .TIMEOUT   (TO),
    .IDXW      (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] grant;
    int         idx;
    int         waitLen;
    bit         timedOut;
    int         cnt;
  } expItem_t;

  expItem_t expQ[$];
  int checks = 0;
  int failures = 0;
  int mPtr = 0;
  int mCnt = 0;

  expItem_t monCur;
  bit       monInTxn = 1'b0;
  int       monWait = 0;
  int       monHoldIdx = 0;
  int       monHoldCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin reference: first requester at or after p, with wrap.
  function automatic int rrPick(input logic [4:0] r, input int p);
    logic [4:0] t;
    for (int i = 0; i < NC; i++) begin
      int k;
      k = (p + i) % NC;
      t = r >> k;
      if (t[0]) return k;
    end
    return -1;
  endfunction

  function automatic expItem_t modelPush(input logic [4:0] req, input bit useDone, input int doneAt);
    expItem_t it;
    it.idx      = rrPick(req, mPtr);
    it.grant    = 5'(1) << it.idx;
    it.waitLen  = useDone ? doneAt + 1 : TO;
    it.timedOut = !useDone;
    if (!useDone && mCnt < 255) mCnt++;
    it.cnt = mCnt;
    mPtr = (it.idx + 1) % NC;
    return it;
  endfunction

  task automatic waitStart(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 4 && !seen; n++) begin
      @(negedge clk);
      seen = bus.start_o;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL start_wait: got no start pulse, expected one within 4 cycles at %0t", $time);
    end
  endtask

  // Called at a negedge while the DUT is in IDLE; returns at the negedge of
  // the next IDLE cycle. doneAt is the WAIT cycle (0-based) carrying done;
  // values outside 0..TO-1 mean done is never raised.
  task automatic applyStimulus(input logic [4:0] req, input int doneAt,
                               input bit doneInStart, input bit scrambleReq);
    bit seen;
    bit useDone;
    useDone = (doneAt >= 0) && (doneAt < TO);
    expQ.push_back(modelPush(req, useDone, doneAt));
    bus.req_i = req;
    waitStart(seen);
    bus.done_i = doneInStart;
    if (useDone) begin
      for (int k = 0; k <= doneAt; k++) begin
        @(negedge clk);
        bus.done_i = 1'b0;
        if (scrambleReq && k == 0) bus.req_i = 5'($urandom_range(0, 31));
      end
      bus.done_i = 1'b1;
      @(negedge clk);
      bus.done_i = 1'b0;
    end else begin
      @(negedge clk);
      bus.done_i = 1'b0;
      if (scrambleReq) bus.req_i = 5'($urandom_range(0, 31));
    end
    for (int n = 0; n < 40 && bus.busy_o; n++) @(negedge clk);
    if (bus.busy_o) begin
      checks++;
      failures++;
      $display("[TB] FAIL busy_wait: got busy_o=1, expected 0 within 40 cycles at %0t", $time);
    end
  endtask

  task automatic idleCycles(input int n);
    bus.req_i = '0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        checkOutput("rst_grant", 32'(bus.grant_o), 32'd0);
        checkOutput("rst_idx", 32'(bus.grant_idx_o), 32'd0);
        checkOutput("rst_start", 32'(bus.start_o), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("rst_timeout", 32'(bus.timeout_o), 32'd0);
        checkOutput("rst_cnt", 32'(bus.timeout_cnt_o), 32'd0);
        monInTxn = 1'b0;
        monHoldIdx = 0;
        monHoldCnt = 0;
        expQ.delete();
      end else if (bus.start_o) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_start: got grant %0h, expected no grant at %0t", bus.grant_o, $time);
        end else begin
          monCur = expQ.pop_front();
          checkOutput("start_grant", 32'(bus.grant_o), 32'(monCur.grant));
          checkOutput("start_idx", 32'(bus.grant_idx_o), 32'(monCur.idx));
          checkOutput("start_busy", 32'(bus.busy_o), 32'd1);
          monHoldIdx = monCur.idx;
          monInTxn = 1'b1;
          monWait = 0;
        end
      end else if (monInTxn) begin
        if (bus.grant_o != '0) begin
          monWait++;
          checkOutput("wait_grant", 32'(bus.grant_o), 32'(monCur.grant));
          checkOutput("wait_busy", 32'(bus.busy_o), 32'd1);
          checkOutput("wait_timeout", 32'(bus.timeout_o), 32'd0);
        end else begin
          checkOutput("wait_len", 32'(monWait), 32'(monCur.waitLen));
          checkOutput("rel_timeout", 32'(bus.timeout_o), 32'(monCur.timedOut));
          checkOutput("rel_cnt", 32'(bus.timeout_cnt_o), 32'(monCur.cnt));
          checkOutput("rel_busy", 32'(bus.busy_o), 32'd1);
          monHoldCnt = monCur.cnt;
          monInTxn = 1'b0;
        end
      end else begin
        checkOutput("idle_grant", 32'(bus.grant_o), 32'd0);
        checkOutput("idle_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("idle_timeout", 32'(bus.timeout_o), 32'd0);
        checkOutput("idle_idx_hold", 32'(bus.grant_idx_o), 32'(monHoldIdx));
        checkOutput("idle_cnt_hold", 32'(bus.timeout_cnt_o), 32'(monHoldCnt));
      end
    end
  end

  initial begin : driver
    bit seen;
    expItem_t it;
    bus.req_i = '0;
    bus.done_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness with all requests held: 0,1,2,3,4,0.
    repeat (6) applyStimulus(5'b11111, 0, 1'b0, 1'b0);

    // Single request (ptr=1) then wrap from ptr=3.
    applyStimulus(5'b00100, 1, 1'b0, 1'b0);
    applyStimulus(5'b00011, 0, 1'b0, 1'b0);
    applyStimulus(5'b00011, 0, 1'b0, 1'b0);

    // Watchdog expiry, then done coincident with the last WAIT cycle.
    applyStimulus(5'b00010, -1, 1'b0, 1'b0);
    applyStimulus(5'b00010, TO - 1, 1'b0, 1'b0);

    // done during START is ignored; request changes mid-WAIT are ignored.
    applyStimulus(5'b10110, 2, 1'b1, 1'b0);
    applyStimulus(5'b01000, 3, 1'b0, 1'b1);
    idleCycles(3);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      applyStimulus(5'($urandom_range(1, 31)), int'($urandom_range(0, 20)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 2)));
    end

    // Timeout counter saturation.
    repeat (300) applyStimulus(5'($urandom_range(1, 31)), -1, 1'b0, 1'b0);

    // Reset in the middle of WAIT.
    it = modelPush(5'b01000, 1'b1, 0);
    expQ.push_back(it);
    bus.req_i = 5'b01000;
    waitStart(seen);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus.req_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mPtr = 0;
    mCnt = 0;
    applyStimulus(5'b10001, 0, 1'b0, 1'b0);
    applyStimulus(5'b10000, 0, 1'b0, 1'b0);

    idleCycles(3);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/root_child_scheduler.md
# root_child_scheduler

Round-robin scheduler that shares the five child instances under a root module as one execution resource. It accepts up to five request lines and grants exactly one child at a time. It issues a one-cycle start pulse to the granted child, holds the grant until that child reports done or a watchdog expires, then releases the grant and moves fairness priority past the winner. It sits in the root module between the request sources and the `inst_0`..`inst_4` children.

## Interface
- `NUM_CHILD`, 5: number of requesters/children; minimum 2.
- `TIMEOUT`, 16: cycles in WAIT without `done_i` before forced release; minimum 1.
- `IDXW`, `$clog2(NUM_CHILD)`: width of index outputs (derived).
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_i`  in  NUM_CHILD  level request per child; bit k = `inst_k`.
- `done_i`  in  1  completion pulse from the currently granted child.
- `grant_o`  out  NUM_CHILD  one-hot grant, or all-zero.
- `grant_idx_o`  out  IDXW  binary index of current/last grant.
- `start_o`  out  1  one-cycle start pulse to the granted child.
- `busy_o`  out  1  high in START, WAIT, RELEASE.
- `timeout_o`  out  1  one-cycle pulse on watchdog expiry.
- `timeout_cnt_o`  out  8  saturating count of timeouts.

## Operation
- FSM states: IDLE, START, WAIT, RELEASE.
- **IDLE:** if any `req_i` bit is set, pick the first set bit at or after `ptr`, searching upward with wrap, and go to START. Otherwise stay in IDLE.
- **START:** lasts one cycle. `grant_o` is the one-hot of the pick, `start_o` is 1, and the watchdog is cleared to 0. `done_i` is ignored in START. Next state is WAIT.
- **WAIT:** `grant_o` is held and the watchdog increments every cycle.
  - `done_i`=1: go to RELEASE.
  - Otherwise, watchdog == TIMEOUT-1: pulse `timeout_o`, increment `timeout_cnt_o` (saturating at 255), go to RELEASE.
  - `done_i` and expiry in the same cycle: done wins; no timeout pulse, no count.
- **RELEASE:** lasts one cycle. `grant_o`=0. `ptr` becomes (granted index + 1) mod NUM_CHILD. Next state is IDLE.
- A requester that drops `req_i` while granted does not end the grant; only done or timeout ends it.
- `req_i` changes outside IDLE are ignored. Arbitration samples only in IDLE.
- `done_i` outside WAIT is ignored.
- `grant_idx_o` updates on entry to START and holds its value through IDLE.
- Reset values: state=IDLE, `ptr`=0, `grant_o`=0, `grant_idx_o`=0, `start_o`=0, `busy_o`=0, `timeout_o`=0, `timeout_cnt_o`=0.
- Reset asserted mid-transaction: all of the above take effect on the next edge. No RELEASE cycle is emitted and no done is expected afterwards.

## Timing
- All outputs are registered.
- `req_i` seen in IDLE at edge N:
  - `grant_o` and `start_o` high from N+1 (START).
  - WAIT from N+2.
- `done_i` seen at edge M in WAIT:
  - RELEASE from M+1, with `grant_o` low.
  - IDLE from M+2.
  - Earliest next grant at M+3.
- Minimum transaction is 4 cycles: START, one WAIT, RELEASE, IDLE.
- Timeout path: WAIT lasts exactly TIMEOUT cycles. `timeout_o` is high in the cycle after the last WAIT cycle, coincident with RELEASE.
- `grant_o` is never non-zero in two consecutive transactions without an intervening zero cycle.

## Structure
- Package `root_sched_pkg` holds:
  - the state enum `sched_state_t` {IDLE, START, WAIT, RELEASE};
  - `NUM_CHILD_DEFAULT`=5 and `TIMEOUT_DEFAULT`=16;
  - the shared 8-bit counter width constant.
- One combinational sub-module, `rr_pick`. Inputs are `req` and `ptr`; outputs are `valid` and `idx`, the first set bit at or after `ptr` with wrap. It is reusable by other root-level arbiters.
- The top module holds the FSM, `ptr`, the watchdog, and the output registers.

## Test plan
- Reset then single request: `req_i`=5'b00100 → grant_o=5'b00100 and `start_o`=1 one cycle later; `done_i` two cycles later → grant_o=0 next cycle; `grant_idx_o`=2; `ptr`=3.
- Fairness: `req_i`=5'b11111 held, `done_i` pulsed on the first WAIT cycle of every grant → grant order is idx 0,1,2,3,4,0, with exactly one zero-grant cycle plus one IDLE cycle between grants.
- Wrap: `ptr`=3 (after a grant to idx 2) and `req_i`=5'b00011 → grant idx 0, then idx 1.
- Watchdog: grant idx 1, never assert `done_i` → exactly 16 WAIT cycles, then `timeout_o`=1 for one cycle, `timeout_cnt_o`=1; `done_i` coincident with the 16th WAIT cycle → no timeout and the count is unchanged.
- Ignored inputs:
  - `done_i` in START has no effect.
  - Dropping `req_i` mid-WAIT keeps the grant.
  - 300 forced timeouts leave `timeout_cnt_o` at 255.
- Mid-operation reset: assert `rst_n`=0 during WAIT → next edge all outputs are 0 and state is IDLE; after release, `req_i`=5'b10000 → grant idx 4 (ptr was reset to 0).
